vx_dispatch_arb_buf: RTL and testbench



---
 rtl/vx_gpu_pkg.sv | 13 +
 rtl/vx_dispatch_fifo.sv | 77 +++++++
 rtl/vx_dispatch_arb_buf.sv | 158 +++++++++++++++
 tb/tb_vx_dispatch_arb_buf.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/vx_gpu_pkg.sv
// Shared definitions for the dispatch path.
//   DISPATCH_ARB_RR / DISPATCH_ARB_PRIO : arbitration mode encodings
//   dispatch_sel_width()                 : width of a channel index (min 1 bit)
package vx_gpu_pkg;

  localparam int DISPATCH_ARB_RR   = 0;
  localparam int DISPATCH_ARB_PRIO = 1;

  function automatic int dispatch_sel_width(input int num_inputs);
    return (num_inputs > 1) ? $clog2(num_inputs) : 1;
  endfunction

endpackage

// File: rtl/vx_dispatch_fifo.sv
// Single-channel DEPTH-entry dispatch FIFO with registered storage.
//   clk, reset_n      : clock, async active-low reset
//   flush             : synchronous clear; overrides push and pop
//   push, data_in     : write request and payload (ignored when full)
//   pop               : read request (ignored when empty)
//   data_out          : current head entry
//   full, empty, count: occupancy status
module vx_dispatch_fifo
  import vx_gpu_pkg::*;
#(
  parameter int DATA_WIDTH = 256,
  parameter int DEPTH      = 4
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    flush,
  input  logic                    push,
  input  logic [DATA_WIDTH-1:0]   data_in,
  input  logic                    pop,
  output logic [DATA_WIDTH-1:0]   data_out,
  output logic                    full,
  output logic                    empty,
  output logic [$clog2(DEPTH):0]  count
);

  localparam int AW = $clog2(DEPTH);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [AW:0]           count_q, count_d;
  logic                  push_en, pop_en;

  assign full     = (count_q == (AW+1)'(DEPTH));
  assign empty    = (count_q == '0);
  assign count    = count_q;
  assign data_out = mem_q[rd_ptr_q];
  assign push_en  = push && !full && !flush;
  assign pop_en   = pop && !empty && !flush;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_en) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop_en)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({push_en, pop_en})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Payload storage needs no reset: an entry is only read once count covers it.
  always_ff @(posedge clk) begin
    if (push_en) mem_q[wr_ptr_q] <= data_in;
  end

endmodule

// File: rtl/vx_dispatch_arb_buf.sv
// N-to-1 dispatch concentrator: per-channel FIFOs, round-robin or fixed
// priority arbitration, optional registered output stage.
//   clk, reset_n        : clock, async active-low reset
//   flush               : synchronous clear of all buffered and in-flight entries
//   valid_in/data_in    : per-channel dispatch streams (channel i at [i*DATA_WIDTH +: DATA_WIDTH])
//   ready_in            : per-channel ready (independent of ready_out)
//   valid_out/data_out  : concentrated output stream
//   sel_out             : source channel of data_out
//   ready_out           : downstream ready
//   full_out            : per-channel FIFO full
module vx_dispatch_arb_buf
  import vx_gpu_pkg::*;
#(
  parameter int NUM_INPUTS = 4,
  parameter int DATA_WIDTH = 256,
  parameter int DEPTH      = 4,
  parameter int ARB_MODE   = DISPATCH_ARB_RR,
  parameter int OUT_REG    = 1
) (
  input  logic                                      clk,
  input  logic                                      reset_n,
  input  logic                                      flush,
  input  logic [NUM_INPUTS-1:0]                     valid_in,
  input  logic [NUM_INPUTS*DATA_WIDTH-1:0]          data_in,
  output logic [NUM_INPUTS-1:0]                     ready_in,
  output logic                                      valid_out,
  output logic [DATA_WIDTH-1:0]                     data_out,
  output logic [dispatch_sel_width(NUM_INPUTS)-1:0] sel_out,
  input  logic                                      ready_out,
  output logic [NUM_INPUTS-1:0]                     full_out
);

  localparam int SEL_W = dispatch_sel_width(NUM_INPUTS);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic [NUM_INPUTS-1:0] full, empty, push, pop, nonempty;
  logic [CNT_W-1:0]      cnt  [NUM_INPUTS];
  logic [DATA_WIDTH-1:0] head [NUM_INPUTS];

  logic [SEL_W-1:0]      rr_q, rr_d;
  logic                  out_valid_q, out_valid_d;
  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic [SEL_W-1:0]      out_sel_q, out_sel_d;
  logic                  lock_q, lock_d;
  logic [SEL_W-1:0]      lock_sel_q, lock_sel_d;

  logic                  win_any, can_accept, gnt_any;
  logic [SEL_W-1:0]      win_idx, cand;

  function automatic logic [SEL_W-1:0] rr_idx(input logic [SEL_W-1:0] base, input int k);
    return SEL_W'((int'(base) + k) % NUM_INPUTS);
  endfunction

  function automatic logic [SEL_W-1:0] next_ptr(input logic [SEL_W-1:0] cur);
    int nxt;
    nxt = int'(cur) + 1;
    if (nxt >= NUM_INPUTS) nxt = 0;
    return SEL_W'(nxt);
  endfunction

  assign ready_in = ~full & {NUM_INPUTS{reset_n & ~flush}};
  assign push     = valid_in & ready_in;
  assign full_out = full;

  for (genvar i = 0; i < NUM_INPUTS; i++) begin : g_ch
    vx_dispatch_fifo #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (DEPTH)
    ) u_fifo (
      .clk      (clk),
      .reset_n  (reset_n),
      .flush    (flush),
      .push     (push[i]),
      .data_in  (data_in[i*DATA_WIDTH +: DATA_WIDTH]),
      .pop      (pop[i]),
      .data_out (head[i]),
      .full     (full[i]),
      .empty    (empty[i]),
      .count    (cnt[i])
    );
    assign nonempty[i] = |cnt[i];

    a_no_push_full: assert property (@(posedge clk) disable iff (!reset_n) !(push[i] && full[i]));
    a_no_pop_empty: assert property (@(posedge clk) disable iff (!reset_n) !(pop[i] && empty[i]));
  end

  // Lowest search offset wins: the loop walks downward so the last hit is kept.
  // A stalled combinational output stays locked on its channel so that a new
  // arrival on a higher-priority channel cannot swap the presented payload.
  always_comb begin
    win_any = 1'b0;
    win_idx = '0;
    cand    = '0;
    if (lock_q) begin
      win_any = 1'b1;
      win_idx = lock_sel_q;
    end else begin
      for (int k = NUM_INPUTS-1; k >= 0; k--) begin
        cand = (ARB_MODE == DISPATCH_ARB_PRIO) ? SEL_W'(k) : rr_idx(rr_q, k);
        if (nonempty[cand]) begin
          win_any = 1'b1;
          win_idx = cand;
        end
      end
    end
  end

  assign can_accept = (OUT_REG != 0) ? (!out_valid_q || ready_out) : ready_out;
  assign gnt_any    = win_any && can_accept && !flush;
  assign pop        = gnt_any ? (NUM_INPUTS'(1) << win_idx) : '0;

  always_comb begin
    rr_d        = rr_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_sel_d   = out_sel_q;
    lock_d      = (OUT_REG == 0) && win_any && !ready_out && !flush;
    lock_sel_d  = win_idx;
    if (flush) begin
      rr_d        = '0;
      out_valid_d = 1'b0;
    end else begin
      if (gnt_any) rr_d = next_ptr(win_idx);
      if (!out_valid_q || ready_out) begin
        out_valid_d = gnt_any;
        if (gnt_any) begin
          out_data_d = head[win_idx];
          out_sel_d  = win_idx;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rr_q        <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sel_q   <= '0;
      lock_q      <= 1'b0;
      lock_sel_q  <= '0;
    end else begin
      rr_q        <= rr_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_sel_q   <= out_sel_d;
      lock_q      <= lock_d;
      lock_sel_q  <= lock_sel_d;
    end
  end

  assign valid_out = (OUT_REG != 0) ? out_valid_q : win_any;
  assign data_out  = (OUT_REG != 0) ? out_data_q  : (win_any ? head[win_idx] : '0);
  assign sel_out   = (OUT_REG != 0) ? out_sel_q   : (win_any ? win_idx : '0);

  a_grant_onehot: assert property (@(posedge clk) disable iff (!reset_n) $onehot0(pop));

endmodule

// File: tb/tb_vx_dispatch_arb_buf.sv
module tb_vx_dispatch_arb_buf;
  localparam int NI  = 4;
  localparam int DW  = 16;
  localparam int DEP = 4;
  localparam int ND  = 3;   // 0: RR + out reg, 1: PRIO + out reg, 2: RR + comb out

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             reset_n, flush, ready_out;
  logic [NI-1:0]    valid_in;
  logic [NI*DW-1:0] data_in;
  logic [NI-1:0]    ri   [ND];
  logic             vo   [ND];
  logic [DW-1:0]    dout [ND];
  logic [1:0]       so   [ND];
  logic [NI-1:0]    fo   [ND];

  vx_dispatch_arb_buf #(.NUM_INPUTS(NI), .DATA_WIDTH(DW), .DEPTH(DEP), .ARB_MODE(0), .OUT_REG(1)) u_rr (
    .clk(clk), .reset_n(reset_n), .flush(flush), .valid_in(valid_in), .data_in(data_in),
    .ready_in(ri[0]), .valid_out(vo[0]), .data_out(dout[0]), .sel_out(so[0]),
    .ready_out(ready_out), .full_out(fo[0]));
  vx_dispatch_arb_buf #(.NUM_INPUTS(NI), .DATA_WIDTH(DW), .DEPTH(DEP), .ARB_MODE(1), .OUT_REG(1)) u_pr (
    .clk(clk), .reset_n(reset_n), .flush(flush), .valid_in(valid_in), .data_in(data_in),
    .ready_in(ri[1]), .valid_out(vo[1]), .data_out(dout[1]), .sel_out(so[1]),
    .ready_out(ready_out), .full_out(fo[1]));
  vx_dispatch_arb_buf #(.NUM_INPUTS(NI), .DATA_WIDTH(DW), .DEPTH(DEP), .ARB_MODE(0), .OUT_REG(0)) u_cb (
    .clk(clk), .reset_n(reset_n), .flush(flush), .valid_in(valid_in), .data_in(data_in),
    .ready_in(ri[2]), .valid_out(vo[2]), .data_out(dout[2]), .sel_out(so[2]),
    .ready_out(ready_out), .full_out(fo[2]));

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Behavioural reference: one queue per channel, plus the visible output state.
  logic [DW-1:0] mq [ND][NI][$];
  int            m_rr   [ND];
  bit            m_ov   [ND];
  logic [DW-1:0] m_od   [ND];
  int            m_os   [ND];
  bit            m_lock [ND];
  int            m_lsel [ND];

  function automatic bit is_prio(int d); return d == 1; endfunction
  function automatic bit has_oreg(int d); return d != 2; endfunction

  task automatic model_reset();
    for (int d = 0; d < ND; d++) begin
      for (int c = 0; c < NI; c++) mq[d][c].delete();
      m_rr[d] = 0; m_ov[d] = 0; m_od[d] = '0; m_os[d] = 0; m_lock[d] = 0; m_lsel[d] = 0;
    end
  endtask

  function automatic int m_winner(int d);
    int c;
    if (!has_oreg(d) && m_lock[d]) return m_lsel[d];
    for (int k = 0; k < NI; k++) begin
      c = is_prio(d) ? k : (m_rr[d] + k) % NI;
      if (mq[d][c].size() > 0) return c;
    end
    return -1;
  endfunction

  task automatic model_step();
    for (int d = 0; d < ND; d++) begin
      int w;
      bit can, grant;
      bit acc [NI];
      logic [DW-1:0] h;
      w     = m_winner(d);
      can   = has_oreg(d) ? (!m_ov[d] || ready_out) : ready_out;
      grant = (w >= 0) && can && !flush;
      for (int c = 0; c < NI; c++) acc[c] = valid_in[c] && (mq[d][c].size() < DEP) && !flush;
      if (flush) begin
        for (int c = 0; c < NI; c++) mq[d][c].delete();
        m_ov[d] = 0; m_rr[d] = 0; m_lock[d] = 0;
      end else begin
        if (grant) begin
          h = mq[d][w].pop_front();
          m_rr[d] = (w + 1) % NI;
          if (has_oreg(d)) begin m_od[d] = h; m_os[d] = w; end
        end
        if (has_oreg(d) && can) m_ov[d] = grant;
        if (!has_oreg(d)) begin m_lock[d] = (w >= 0) && !ready_out; m_lsel[d] = w; end
        for (int c = 0; c < NI; c++) if (acc[c]) mq[d][c].push_back(data_in[c*DW +: DW]);
      end
    end
  endtask

  task automatic model_check();
    for (int d = 0; d < ND; d++) begin
      logic [NI-1:0] er, ef;
      int w;
      bit ev;
      logic [DW-1:0] ed;
      int es;
      for (int c = 0; c < NI; c++) begin
        er[c] = (mq[d][c].size() < DEP) && !flush;
        ef[c] = (mq[d][c].size() == DEP);
      end
      chk($sformatf("ready_in dut%0d", d), 64'(ri[d]), 64'(er));
      chk($sformatf("full_out dut%0d", d), 64'(fo[d]), 64'(ef));
      w  = m_winner(d);
      ev = has_oreg(d) ? m_ov[d] : (w >= 0);
      chk($sformatf("valid_out dut%0d", d), 64'(vo[d]), 64'(ev));
      if (ev) begin
        if (has_oreg(d)) begin ed = m_od[d]; es = m_os[d]; end
        else begin ed = mq[d][w][0]; es = w; end
        chk($sformatf("data_out dut%0d", d), 64'(dout[d]), 64'(ed));
        chk($sformatf("sel_out dut%0d", d), 64'(so[d]), 64'(es));
      end
    end
  endtask

  task automatic half1(); @(negedge clk); model_check(); endtask
  task automatic half2(); @(posedge clk); model_step(); #1; endtask

  task automatic chk_reset_outputs(input string tag);
    for (int d = 0; d < ND; d++) begin
      chk($sformatf("%s ready_in dut%0d", tag, d), 64'(ri[d]), 64'(0));
      chk($sformatf("%s valid_out dut%0d", tag, d), 64'(vo[d]), 64'(0));
      chk($sformatf("%s data_out dut%0d", tag, d), 64'(dout[d]), 64'(0));
      chk($sformatf("%s sel_out dut%0d", tag, d), 64'(so[d]), 64'(0));
      chk($sformatf("%s full_out dut%0d", tag, d), 64'(fo[d]), 64'(0));
    end
  endtask

  typedef struct {
    logic          fl;
    logic [NI-1:0] vin;
    logic [NI*DW-1:0] din;
    logic          ev;
    logic [1:0]    es_rr;
    logic [DW-1:0] ed_rr;
    logic [1:0]    es_pr;
    logic [DW-1:0] ed_pr;
  } vec_t;

  function automatic vec_t mk(logic fl, logic [NI-1:0] vin, logic [NI*DW-1:0] din, logic ev,
                              logic [1:0] sr, logic [DW-1:0] dr, logic [1:0] sp, logic [DW-1:0] dp);
    vec_t v;
    v.fl = fl; v.vin = vin; v.din = din; v.ev = ev;
    v.es_rr = sr; v.ed_rr = dr; v.es_pr = sp; v.ed_pr = dp;
    return v;
  endfunction

  vec_t tbl [15];

  initial begin
    localparam logic [NI*DW-1:0] A5 = 64'h0000_00A5_0000_0000;
    localparam logic [NI*DW-1:0] B0 = 64'h0103_0102_0101_0100;
    localparam logic [NI*DW-1:0] B1 = 64'h0113_0112_0111_0110;
    localparam logic [NI*DW-1:0] B2 = 64'h0123_0122_0121_0120;
    // Latency, then flush to zero the RR pointer, then 4-channel contention.
    tbl[0]  = mk(0, 4'b0100, A5, 0, 0, 16'h0,   0, 16'h0);
    tbl[1]  = mk(0, 4'b0000, 0,  0, 0, 16'h0,   0, 16'h0);
    tbl[2]  = mk(0, 4'b0000, 0,  1, 2, 16'hA5,  2, 16'hA5);
    tbl[3]  = mk(0, 4'b0000, 0,  0, 0, 16'h0,   0, 16'h0);
    tbl[4]  = mk(1, 4'b0000, 0,  0, 0, 16'h0,   0, 16'h0);
    tbl[5]  = mk(0, 4'b1111, B0, 0, 0, 16'h0,   0, 16'h0);
    tbl[6]  = mk(0, 4'b1111, B1, 0, 0, 16'h0,   0, 16'h0);
    tbl[7]  = mk(0, 4'b1111, B2, 1, 0, 16'h100, 0, 16'h100);
    tbl[8]  = mk(0, 4'b0000, 0,  1, 1, 16'h101, 0, 16'h110);
    tbl[9]  = mk(0, 4'b0000, 0,  1, 2, 16'h102, 0, 16'h120);
    tbl[10] = mk(0, 4'b0000, 0,  1, 3, 16'h103, 1, 16'h101);
    tbl[11] = mk(0, 4'b0000, 0,  1, 0, 16'h110, 1, 16'h111);
    tbl[12] = mk(0, 4'b0000, 0,  1, 1, 16'h111, 1, 16'h121);
    tbl[13] = mk(1, 4'b0000, 0,  1, 2, 16'h112, 2, 16'h102);
    tbl[14] = mk(0, 4'b0000, 0,  0, 0, 16'h0,   0, 16'h0);

    reset_n = 1'b0; flush = 1'b0; ready_out = 1'b1; valid_in = '1; data_in = '1;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_reset_outputs("reset");
    valid_in = '0;
    reset_n  = 1'b1;
    @(posedge clk); #1;
    half1();
    for (int d = 0; d < ND; d++) chk($sformatf("post-reset ready_in dut%0d", d), 64'(ri[d]), 64'hF);
    half2();

    for (int r = 0; r < 15; r++) begin
      flush = tbl[r].fl; valid_in = tbl[r].vin; data_in = tbl[r].din; ready_out = 1'b1;
      half1();
      chk($sformatf("tbl%0d rr valid", r), 64'(vo[0]), 64'(tbl[r].ev));
      chk($sformatf("tbl%0d pr valid", r), 64'(vo[1]), 64'(tbl[r].ev));
      if (tbl[r].ev) begin
        chk($sformatf("tbl%0d rr sel", r),  64'(so[0]),   64'(tbl[r].es_rr));
        chk($sformatf("tbl%0d rr data", r), 64'(dout[0]), 64'(tbl[r].ed_rr));
        chk($sformatf("tbl%0d pr sel", r),  64'(so[1]),   64'(tbl[r].es_pr));
        chk($sformatf("tbl%0d pr data", r), 64'(dout[1]), 64'(tbl[r].ed_pr));
      end
      half2();
    end

    // Backpressure on channel 1 with ready_out low, then drain.
    for (int k = 0; k < 6; k++) begin
      flush = 1'b0; ready_out = 1'b0; valid_in = 4'b0010;
      data_in = '0; data_in[DW +: DW] = 16'(16'h200 + k);
      half1();
      if (k == 4) begin
        chk("bp comb full1",  64'(fo[2][1]), 64'(1));
        chk("bp comb ready1", 64'(ri[2][1]), 64'(0));
        chk("bp reg full1 early", 64'(fo[0][1]), 64'(0));
      end
      if (k == 5) begin
        chk("bp reg full1",  64'(fo[0][1]), 64'(1));
        chk("bp reg ready1", 64'(ri[0][1]), 64'(0));
      end
      if (k >= 2) chk("bp reg stable data", 64'(dout[0]), 64'h200);
      if (k >= 1) chk("bp comb stable data", 64'(dout[2]), 64'h200);
      half2();
    end
    for (int k = 0; k < 5; k++) begin
      valid_in = '0; ready_out = 1'b1;
      half1();
      chk($sformatf("drain reg data %0d", k), 64'(dout[0]), 64'(16'h200 + k));
      if (k < 4) chk($sformatf("drain comb data %0d", k), 64'(dout[2]), 64'(16'h200 + k));
      else       chk("drain comb empty", 64'(vo[2]), 64'(0));
      half2();
    end

    // Flush with three buffered entries and a same-cycle push.
    for (int k = 0; k < 3; k++) begin
      valid_in = 4'b0001; ready_out = 1'b0; data_in = '0; data_in[DW-1:0] = 16'(16'h300 + k);
      half1(); half2();
    end
    flush = 1'b1; valid_in = 4'b0001; data_in = '0; data_in[DW-1:0] = 16'h3FF;
    half1(); half2();
    flush = 1'b0; valid_in = '0; ready_out = 1'b1;
    for (int k = 0; k < 4; k++) begin
      half1();
      for (int d = 0; d < ND; d++) begin
        chk($sformatf("flush valid dut%0d c%0d", d, k), 64'(vo[d]), 64'(0));
        if (k == 0) chk($sformatf("flush full dut%0d", d), 64'(fo[d]), 64'(0));
      end
      half2();
    end

    // Randomised traffic against the reference, with one asynchronous reset mid-run.
    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) begin
        valid_in = 4'($urandom); ready_out = 1'b0; flush = 1'b0;
        #2;
        reset_n = 1'b0;
        #1;
        chk_reset_outputs("mid-reset");
        model_reset();
        valid_in = '0;
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk); #1;
      end
      valid_in  = 4'($urandom);
      data_in   = {$urandom, $urandom};
      ready_out = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 39) == 0);
      half1();
      half2();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
